// File: rtl/mm_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mm_pkg - FSM states, mode codes and address helper   rev 1.0        |
// +---------------------------------------------------------------------+
package mm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD_C = 4'd1,
    ST_INIT   = 4'd2,
    ST_RD_A   = 4'd3,
    ST_RD_B   = 4'd4,
    ST_MUL    = 4'd5,
    ST_ACC    = 4'd6,
    ST_WRITE  = 4'd7,
    ST_DONE   = 4'd8
  } mm_state_e;

  localparam logic [1:0] MM_MUL   = 2'd0;
  localparam logic [1:0] MM_MUL_T = 2'd1;
  localparam logic [1:0] MM_ACC   = 2'd2;

  // Column-major element address; bases need no alignment.
  function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                            input logic [31:0] row,
                                            input logic [31:0] col,
                                            input logic [31:0] n);
    return base + row + col * n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_mac.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mm_mac - multiply-accumulate datapath with saturation   rev 1.0     |
// +---------------------------------------------------------------------+
module mm_mac
  import mm_pkg::*;
#(
  parameter int EW = 8,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_ovf,
  input  logic          i_init,
  input  logic          i_init_rd,
  input  logic          i_lda,
  input  logic          i_mul,
  input  logic          i_acc,
  input  logic          i_wr,
  input  logic [DW-1:0] i_rdata,
  output logic [DW-1:0] o_wdata,
  output logic          o_ovf
);

  logic [EW-1:0]   r_a;
  logic [2*EW-1:0] r_prod;
  logic [DW:0]     r_acc;
  logic            r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_init)
        r_acc <= i_init_rd ? {1'b0, i_rdata} : '0;
      else if (i_acc)
        r_acc <= r_acc + (DW+1)'(r_prod);
      if (i_lda)
        r_a <= i_rdata[EW-1:0];
      if (i_mul)
        r_prod <= (2*EW)'(r_a) * (2*EW)'(i_rdata[EW-1:0]);
      if (i_clr_ovf)
        r_ovf <= 1'b0;
      else if (i_wr && r_acc[DW])
        r_ovf <= 1'b1;
    end
  end

  // The extra accumulator bit can only be set when a preloaded C is added in.
  assign o_wdata = r_acc[DW] ? '1 : r_acc[DW-1:0];
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/mat_mult_engine.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | mat_mult_engine - sequential NxN SRAM matrix multiplier   rev 1.0   |
// +---------------------------------------------------------------------+
module mat_mult_engine
  import mm_pkg::*;
#(
  parameter int N      = 4,
  parameter int EW     = 8,
  parameter int DW     = 18,
  parameter int AW     = 11,
  parameter int A_BASE = 0,
  parameter int B_BASE = N*N,
  parameter int C_BASE = 2*N*N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            c_iw   = $clog2(N);
  localparam logic [c_iw-1:0] c_last = c_iw'(N-1);

  if (2*EW + $clog2(N) > DW) begin : g_dw_too_small
    $error("mat_mult_engine: DW cannot hold an N-term sum of EW x EW products");
  end
  if (N < 2 || (N & (N-1)) != 0) begin : g_bad_n
    $error("mat_mult_engine: N must be a power of two >= 2");
  end

  mm_state_e       r_state, w_next;
  logic [1:0]      r_mode;
  logic [c_iw-1:0] r_i, r_j, r_k;

  logic            w_accept, w_k_last, w_last_elem, w_mode_acc, w_mode_t;
  logic            w_en, w_we, w_init, w_lda, w_mul, w_acc;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;

  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_k_last    = (r_k == c_last);
  assign w_last_elem = (r_i == c_last) && (r_j == c_last);
  assign w_mode_acc  = (r_mode == MM_ACC);
  assign w_mode_t    = (r_mode == MM_MUL_T);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MM_MUL;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (start) begin
          r_mode <= mode;
          r_i    <= '0;
          r_j    <= '0;
          r_k    <= '0;
        end
        ST_INIT: r_k <= '0;
        ST_ACC:  if (!w_k_last) r_k <= r_k + c_iw'(1);
        ST_WRITE: begin
          if (r_j == c_last) begin
            r_j <= '0;
            r_i <= r_i + c_iw'(1);
          end else begin
            r_j <= r_j + c_iw'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_we   = 1'b0;
    w_init = 1'b0;
    w_lda  = 1'b0;
    w_mul  = 1'b0;
    w_acc  = 1'b0;
    w_addr = '0;
    case (r_state)
      ST_IDLE:
        if (start) w_next = (mode == MM_ACC) ? ST_LOAD_C : ST_INIT;
      ST_LOAD_C: begin
        w_en   = 1'b1;
        w_addr = AW'(elem_addr(32'(C_BASE), 32'(r_i), 32'(r_j), 32'(N)));
        w_next = ST_INIT;
      end
      ST_INIT: begin
        w_init = 1'b1;
        w_next = ST_RD_A;
      end
      ST_RD_A: begin
        w_en   = 1'b1;
        w_addr = AW'(elem_addr(32'(A_BASE), 32'(r_i), 32'(r_k), 32'(N)));
        w_next = ST_RD_B;
      end
      ST_RD_B: begin
        w_en   = 1'b1;
        w_lda  = 1'b1;
        // Transposed mode swaps row and column of the B fetch.
        w_addr = w_mode_t ? AW'(elem_addr(32'(B_BASE), 32'(r_j), 32'(r_k), 32'(N)))
                          : AW'(elem_addr(32'(B_BASE), 32'(r_k), 32'(r_j), 32'(N)));
        w_next = ST_MUL;
      end
      ST_MUL: begin
        w_mul  = 1'b1;
        w_next = ST_ACC;
      end
      ST_ACC: begin
        w_acc  = 1'b1;
        w_next = w_k_last ? ST_WRITE : ST_RD_A;
      end
      ST_WRITE: begin
        w_en   = 1'b1;
        w_we   = 1'b1;
        w_addr = AW'(elem_addr(32'(C_BASE), 32'(r_i), 32'(r_j), 32'(N)));
        if (w_last_elem)     w_next = ST_DONE;
        else if (w_mode_acc) w_next = ST_LOAD_C;
        else                 w_next = ST_INIT;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  mm_mac #(
    .EW (EW),
    .DW (DW)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .i_clr_ovf (w_accept),
    .i_init    (w_init),
    .i_init_rd (w_mode_acc),
    .i_lda     (w_lda),
    .i_mul     (w_mul),
    .i_acc     (w_acc),
    .i_wr      (w_we),
    .i_rdata   (mem_rdata),
    .o_wdata   (w_wdata),
    .o_ovf     (ovf)
  );

  // Memory strobes are masked by rst so a reset landing on WRITE never commits.
  assign mem_en    = w_en && !rst;
  assign mem_we    = w_we && !rst;
  assign mem_addr  = rst ? '0 : w_addr;
  assign mem_wdata = (w_we && !rst) ? w_wdata : '0;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/mat_mult_engine.md
# mat_mult_engine

Parametrised N×N matrix-multiply engine: the next generation of the fixed 4×4 lab multiplier. It reads operand matrices A and B from a single-port synchronous SRAM, computes C with a sequential multiply-accumulate loop, and writes C back to the same SRAM. It adds a transposed-B mode, an accumulate-into-C mode, saturation with overflow reporting, and a start/busy/done handshake so the UART/LCD display front end can be a separate block.

## Interface
- N, 4, matrix dimension; power of two, ≥2
- EW, 8, element width; element = mem_rdata[EW-1:0], unsigned
- DW, 18, SRAM word width; elaboration error if 2*EW+$clog2(N) > DW
- AW, 11, SRAM address width
- A_BASE, 0, word address of A
- B_BASE, N*N, word address of B
- C_BASE, 2*N*N, word address of C
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; accepted only in IDLE
- mode  in  2  0: C=A×B, 1: C=A×Bᵀ, 2: C=C+A×B, 3: treated as 0; sampled with start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse in DONE
- ovf  out  1  sticky saturation flag; cleared when start is accepted
- mem_en  out  1  SRAM enable
- mem_we  out  1  SRAM write strobe
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid the cycle after the address is presented

## Operation
- Storage is column-major: A[i][k] @ A_BASE+i+k*N; B[k][j] @ B_BASE+k+j*N; Bᵀ[k][j] @ B_BASE+j+k*N; C[i][j] @ C_BASE+i+j*N. Addresses are formed by addition, so bases need no alignment.
- Element order: i outer, j inner: (0,0),(0,1)…(N-1,N-1).
- The FSM has the following states and transitions:
  - IDLE → start → LOAD_C if mode==2, else INIT. Mode is latched, and ovf, i, j, k are zeroed on accept.
  - LOAD_C: drive the C[i][j] address → INIT.
  - INIT: acc ← mode==2 ? mem_rdata : 0; k←0 → RD_A.
  - RD_A: drive the A[i][k] address → RD_B.
  - RD_B: drive the B or Bᵀ address; a ← mem_rdata[EW-1:0] → MUL.
  - MUL: prod ← a × mem_rdata[EW-1:0] (2·EW bits) → ACC.
  - ACC: acc ← acc + prod, k←k+1 → RD_A if k<N-1, else WRITE.
  - WRITE: mem_we=1, C[i][j] address, wdata = acc. Advance (i,j) → DONE if last element; else LOAD_C (mode 2) or INIT.
  - DONE: done=1 → IDLE.
- The accumulator is DW+1 bits. At WRITE, if acc[DW]=1, wdata = all ones and ovf←1. Overflow is only reachable in mode 2.
- mem_en is high in LOAD_C, RD_A, RD_B and WRITE. mem_we is high only in WRITE. mem_addr and mem_wdata are 0 in all other states.
- Reset values: IDLE; busy=done=ovf=mem_en=mem_we=0; mem_addr=mem_wdata=0.

## Timing
- Each k step takes 4 cycles (RD_A, RD_B, MUL, ACC).
- Each element takes 4N+2 cycles, plus 1 cycle in mode 2.
- Total from the accept edge to the done pulse: N²(4N+2) cycles in modes 0/1, N²(4N+3) in mode 2. For N=4 that is 288 / 304.
- start during busy or DONE: ignored, no state change.
- rst mid-operation: IDLE at the next edge, write strobe dropped that edge. C contents are then partially updated and undefined.
- Back-to-back: start in the cycle after DONE is accepted.

## Structure
- Package mm_pkg holds:
  - the state enum;
  - the mode constants MM_MUL, MM_MUL_T, MM_ACC;
  - the address function elem_addr(base, row, col, N).
- Sub-module mm_mac is the datapath: a/prod/acc registers, saturation, and ovf, controlled by load/mul/acc strobes from the FSM.
- The existing sram model is the bench memory, with DATA_WIDTH=DW.

## Test plan
- N=4, mode 0, A=identity, B[k][j]=4k+j+1 → C equals B; done exactly 288 cycles after the accept edge; ovf=0.
- Mode 1, A=identity, same B → C[i][j]=B[j][i]; memory image compared word by word.
- Mode 2, C preloaded to 1, A and B all 2 → every C word = 1+4·4 = 17; 304-cycle latency.
- Mode 2 saturation:
  - setup: N=4, DW=18, C preloaded to 0x3FFF0, A and B all 0xFF;
  - expected: C words = 0x3FFFF; ovf=1 until the next start, which clears it.
- start pulsed during busy and during DONE → ignored; exactly one done pulse per accepted start.
- rst asserted at cycle 100 of a run → IDLE and busy=0 next cycle, no further writes; a fresh start then yields the correct result.
